// File: rtl/mindfocus_pkg.sv
// Shared definitions for the MindFocus input-conditioning stage: controller
// state encoding, default sizes and the one-hot helper.
package mindfocus_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int N_BOTOES_DEF        = 4;
  // 1 ms of stable level at the system clock rate.
  localparam int DEBOUNCE_CICLOS_DEF = CLK_HZ / 1000;

  typedef enum logic [1:0] {
    REPOUSO = 2'd0,
    SEGURA  = 2'd1,
    SOLTA   = 2'd2
  } estado_t;

  function automatic logic exatamente_um(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a stability counter; the output level
// only follows the input after DEBOUNCE_CICLOS consecutive differing samples.
module debounce_bit #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sinal_in,
  output logic sinal_deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the raw level and accept it once it has held long enough.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      sync1_r <= sinal_in;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign sinal_deb = stable_r;

endmodule

// File: rtl/condicionador_botoes.sv
// Conditions the raw play buttons and start key into clean one-cycle strobes
// and a held one-hot play code for the game controller.
module condicionador_botoes
  import mindfocus_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_DEF,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_in,
  input  logic                jogar_in,
  input  logic                limpa,
  output logic [N_BOTOES-1:0] botoes_deb,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_valida,
  output logic                jogada_invalida,
  output logic                jogar_pulso,
  output logic [1:0]          db_estado
);

  estado_t estado_r;
  logic    jogar_deb_s;
  logic    jogar_q_r;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_deb
    debounce_bit #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb (
      .clock    (clock),
      .reset    (reset),
      .sinal_in (botoes_in[i]),
      .sinal_deb(botoes_deb[i])
    );
  end

  debounce_bit #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_jogar (
    .clock    (clock),
    .reset    (reset),
    .sinal_in (jogar_in),
    .sinal_deb(jogar_deb_s)
  );

  // Press evaluation FSM with the held play register and its strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r        <= REPOUSO;
      jogada          <= '0;
      jogada_valida   <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      jogada_valida   <= 1'b0;
      jogada_invalida <= 1'b0;
      // A same-cycle valid press overrides the clear below.
      if (limpa) begin
        jogada <= '0;
      end else begin
        jogada <= jogada;
      end
      case (estado_r)
        REPOUSO: begin
          if (botoes_deb != '0) begin
            if (exatamente_um(32'(botoes_deb))) begin
              jogada        <= botoes_deb;
              jogada_valida <= 1'b1;
            end else begin
              jogada_invalida <= 1'b1;
            end
            estado_r <= SEGURA;
          end else begin
            estado_r <= REPOUSO;
          end
        end
        SEGURA: begin
          if (botoes_deb == '0) begin
            estado_r <= SOLTA;
          end else begin
            estado_r <= SEGURA;
          end
        end
        SOLTA:   estado_r <= REPOUSO;
        default: estado_r <= REPOUSO;
      endcase
    end
  end

  // Rising-edge strobe of the debounced start key.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogar_q_r   <= 1'b0;
      jogar_pulso <= 1'b0;
    end else begin
      jogar_q_r   <= jogar_deb_s;
      jogar_pulso <= jogar_deb_s & ~jogar_q_r;
    end
  end

  assign db_estado = estado_r;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench: directed scenarios plus random bouncy stimulus, all
// compared every cycle against a sample-window reference model.
module tb_condicionador_botoes;

  localparam int NB = 4;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] botoes_in;
  logic          jogar_in;
  logic          limpa;
  logic [NB-1:0] botoes_deb;
  logic [NB-1:0] jogada;
  logic          jogada_valida;
  logic          jogada_invalida;
  logic          jogar_pulso;
  logic [1:0]    db_estado;

  always #5 clock = ~clock;

  condicionador_botoes #(.N_BOTOES(NB), .DEBOUNCE_CICLOS(DB)) dut (
    .clock          (clock),
    .reset          (reset),
    .botoes_in      (botoes_in),
    .jogar_in       (jogar_in),
    .limpa          (limpa),
    .botoes_deb     (botoes_deb),
    .jogada         (jogada),
    .jogada_valida  (jogada_valida),
    .jogada_invalida(jogada_invalida),
    .jogar_pulso    (jogar_pulso),
    .db_estado      (db_estado)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int vcount, icount, pcount;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw samples per clock edge; bit 4 is the start key.
  logic [4:0]    hist[$];
  logic [4:0]    m_deb;
  logic          m_jq;
  int            m_state;
  logic [NB-1:0] m_jogada;
  logic          m_val, m_inv, m_pulse;

  task automatic model_reset();
    hist.delete();
    repeat (DB + 2) hist.push_back(5'b0);
    m_deb = 5'b0; m_jq = 1'b0; m_state = 0;
    m_jogada = '0; m_val = 1'b0; m_inv = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic [4:0] raw, input logic lim);
    logic [4:0] old_deb, new_deb;
    int n;
    old_deb = m_deb;
    new_deb = m_deb;
    hist.push_back(raw);
    n = hist.size();
    // A level is accepted once the DB synchronised samples ending two edges
    // ago all agree and differ from the current debounced level.
    for (int b = 0; b < 5; b++) begin
      int ones = 0;
      for (int k = n - DB - 2; k <= n - 3; k++) ones += int'(hist[k][b]);
      if (ones == DB && !old_deb[b]) new_deb[b] = 1'b1;
      if (ones == 0  &&  old_deb[b]) new_deb[b] = 1'b0;
    end
    void'(hist.pop_front());
    m_val = 1'b0;
    m_inv = 1'b0;
    if (lim) m_jogada = '0;
    if (m_state == 0) begin
      if (old_deb[3:0] != 4'b0) begin
        if ($countones(old_deb[3:0]) == 1) begin
          m_val = 1'b1;
          m_jogada = old_deb[3:0];
        end else begin
          m_inv = 1'b1;
        end
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (old_deb[3:0] == 4'b0) m_state = 2;
    end else begin
      m_state = 0;
    end
    m_pulse = old_deb[4] & ~m_jq;
    m_jq    = old_deb[4];
    m_deb   = new_deb;
  endtask

  task automatic compare_all();
    check_eq("botoes_deb", 32'(botoes_deb), 32'(m_deb[3:0]));
    check_eq("jogada", 32'(jogada), 32'(m_jogada));
    check_eq("jogada_valida", 32'(jogada_valida), 32'(m_val));
    check_eq("jogada_invalida", 32'(jogada_invalida), 32'(m_inv));
    check_eq("jogar_pulso", 32'(jogar_pulso), 32'(m_pulse));
    check_eq("db_estado", 32'(db_estado), 32'(m_state));
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_step({jogar_in, botoes_in}, limpa);
    #1;
    compare_all();
    if (jogada_valida)   vcount++;
    if (jogada_invalida) icount++;
    if (jogar_pulso)     pcount++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    ticks(3);
    reset = 1'b1;
  endtask

  initial begin
    botoes_in = '0; jogar_in = 1'b0; limpa = 1'b0;
    reset = 1'b0;
    model_reset();
    ticks(3);
    reset = 1'b1;
    ticks(20);
    check_eq("idle_estado", 32'(db_estado), 32'd0);

    // Clean press held 20 cycles.
    vcount = 0;
    botoes_in = 4'b0100;
    ticks(20);
    check_eq("clean_cnt", vcount, 32'd1);
    check_eq("clean_jog", 32'(jogada), 32'h4);
    botoes_in = '0;
    ticks(12);

    // Bouncing press.
    vcount = 0;
    repeat (5) begin
      botoes_in = 4'b0001; ticks(2);
      botoes_in = 4'b0000; ticks(1);
    end
    botoes_in = 4'b0001;
    ticks(15);
    check_eq("bounce_cnt", vcount, 32'd1);
    check_eq("bounce_jog", 32'(jogada), 32'h1);
    botoes_in = '0;
    ticks(12);

    // Simultaneous press is invalid and keeps the previous play.
    vcount = 0; icount = 0;
    botoes_in = 4'b0011;
    ticks(15);
    check_eq("simul_inv", icount, 32'd1);
    check_eq("simul_val", vcount, 32'd0);
    check_eq("simul_jog", 32'(jogada), 32'h1);
    botoes_in = '0;
    ticks(12);

    // Staggered press: first settling button wins.
    vcount = 0; icount = 0;
    botoes_in = 4'b0001; ticks(2);
    botoes_in = 4'b0011;
    ticks(15);
    check_eq("stag_val", vcount, 32'd1);
    check_eq("stag_inv", icount, 32'd0);
    check_eq("stag_jog", 32'(jogada), 32'h1);
    botoes_in = '0;
    ticks(12);

    // Start key held, plus clear during a held press.
    pcount = 0;
    jogar_in = 1'b1;
    botoes_in = 4'b1000;
    ticks(12);
    check_eq("hold_jog", 32'(jogada), 32'h8);
    limpa = 1'b1; tick(); limpa = 1'b0;
    check_eq("limpa_jog", 32'(jogada), 32'h0);
    check_eq("limpa_estado", 32'(db_estado), 32'd1);
    ticks(17);
    check_eq("jogar_cnt", pcount, 32'd1);
    jogar_in = 1'b0; botoes_in = '0;
    ticks(12);

    // Async reset mid-hold; held button re-debounces afterwards.
    botoes_in = 4'b0100;
    ticks(12);
    apply_reset();
    check_eq("rst_jog", 32'(jogada), 32'h0);
    vcount = 0;
    ticks(12);
    check_eq("rst_val_cnt", vcount, 32'd1);
    check_eq("rst_jog2", 32'(jogada), 32'h4);
    botoes_in = '0;
    ticks(12);

    // Random bouncy traffic with occasional clears and resets.
    for (int seg = 0; seg < 200; seg++) begin
      logic [3:0] pat;
      int dur;
      if ($urandom_range(0, 3) == 0) pat = 4'($urandom);
      else pat = 4'b0001 << $urandom_range(0, 3);
      dur = $urandom_range(1, 14);
      for (int c = 0; c < dur; c++) begin
        botoes_in = ($urandom_range(0, 5) == 0) ? 4'($urandom) : pat;
        jogar_in  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : 1'(seg % 2);
        limpa     = ($urandom_range(0, 19) == 0);
        tick();
      end
      limpa = 1'b0;
      if (seg % 50 == 49) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
